// File: rtl/genetico_pkg.sv
// Shared types and helpers for the serial genetic-circuit evaluator.
package genetico_pkg;

  localparam int FUNC_W = 3;

  typedef enum logic [FUNC_W-1:0] {
    F_AND  = 3'd0,
    F_OR   = 3'd1,
    F_XOR  = 3'd2,
    F_NAND = 3'd3,
    F_NOR  = 3'd4,
    F_XNOR = 3'd5,
    F_NOTA = 3'd6,
    F_BUFA = 3'd7
  } le_func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Bits needed to index n items; never less than one.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/le_func.sv
// Two-input logic-element function unit, time-shared across all genes.
module le_func
  import genetico_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic              a,
  input  logic              b,
  output logic              y
);

  always_comb begin
    y = 1'b0;
    unique case (le_func_e'(func))
      F_AND:  y = a & b;
      F_OR:   y = a | b;
      F_XOR:  y = a ^ b;
      F_NAND: y = ~(a & b);
      F_NOR:  y = ~(a | b);
      F_XNOR: y = ~(a ^ b);
      F_NOTA: y = ~a;
      F_BUFA: y = a;
    endcase
  end

endmodule

// File: rtl/genetico_serial_eval.sv
// Serial chromosome evaluator: one logic element per clock, result over valid/ready.
// Optional built-in fitness counter enabled by GENETICO_FITNESS_EN.
module genetico_serial_eval
  import genetico_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_LE  = 28,
  parameter int N_OUT = 8,
`ifdef GENETICO_FITNESS_EN
  parameter int FIT_W = 16,
`endif
  localparam int SEL_W  = sel_width(N_IN + N_LE),
  localparam int CFG_W  = FUNC_W + 2*SEL_W,
  localparam int ADDR_W = sel_width(N_LE + N_OUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef GENETICO_FITNESS_EN
  input  logic [N_OUT-1:0]  exp_data,
  input  logic              fit_clr,
  output logic [FIT_W-1:0]  fit_count,
`endif
  output logic [N_OUT-1:0]  out_data
);

  localparam int N_SRC = N_IN + N_LE;
  localparam int IDX_W = sel_width(N_LE);

  state_e                      state, state_nx;
  logic [N_LE-1:0][CFG_W-1:0]  le_gene;
  logic [N_OUT-1:0][SEL_W-1:0] out_gene;
  logic [N_IN-1:0]             in_reg;
  logic [N_LE-1:0]             le_state;
  logic [IDX_W-1:0]            idx;
  logic [2**SEL_W-1:0]         src;
  logic [CFG_W-1:0]            cur;
  logic                        le_y;
  logic [N_OUT-1:0]            capt;

  // Zero padding makes every out-of-range select read 0.
  always_comb begin
    src = '0;
    src[N_SRC-1:0] = {le_state, in_reg};
  end

  assign cur = le_gene[idx];

  le_func u_le_func (
    .func (cur[CFG_W-1 -: FUNC_W]),
    .a    (src[cur[SEL_W-1:0]]),
    .b    (src[cur[2*SEL_W-1 -: SEL_W]]),
    .y    (le_y)
  );

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign capt[k] = src[out_gene[k]];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_EVAL;
      S_EVAL:  if (idx == IDX_W'(N_LE-1)) state_nx = S_CAPT;
      S_CAPT:  state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // le_state is written in place, so lower LEs are already fresh when higher ones read them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le_gene  <= '0;
      out_gene <= '0;
      in_reg   <= '0;
      le_state <= '0;
      idx      <= '0;
      out_data <= '0;
    end else begin
      if (state == S_IDLE && cfg_we) begin
        for (int i = 0; i < N_LE; i++)
          if (cfg_addr == ADDR_W'(i)) le_gene[i] <= cfg_wdata;
        for (int k = 0; k < N_OUT; k++)
          if (cfg_addr == ADDR_W'(N_LE + k)) out_gene[k] <= cfg_wdata[SEL_W-1:0];
      end
      if (state == S_IDLE && in_valid) begin
        in_reg <= in_data;
        idx    <= '0;
      end
      if (state == S_EVAL) begin
        le_state[idx] <= le_y;
        idx           <= idx + 1'b1;
      end
      if (state == S_CAPT) out_data <= capt;
    end
  end

`ifdef GENETICO_FITNESS_EN
  localparam logic [31:0] FIT_MAX = 32'((64'd1 << FIT_W) - 64'd1);

  logic [N_OUT-1:0] exp_reg;
  logic [31:0]      fit_err, fit_sum;

  always_comb begin
    fit_err = '0;
    for (int k = 0; k < N_OUT; k++) fit_err = fit_err + 32'(capt[k] ^ exp_reg[k]);
    fit_sum = (fit_clr ? 32'd0 : 32'(fit_count)) + fit_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_reg   <= '0;
      fit_count <= '0;
    end else begin
      if (state == S_IDLE && in_valid) exp_reg <= exp_data;
      if (state == S_CAPT)  fit_count <= (fit_sum > FIT_MAX) ? '1 : fit_sum[FIT_W-1:0];
      else if (fit_clr)     fit_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_genetico_serial_eval.sv
// Directed bench for genetico_serial_eval; fitness steps run when GENETICO_FITNESS_EN is defined.
module tb_genetico_serial_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [14:0] cfg_wdata;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
`ifdef GENETICO_FITNESS_EN
  logic [7:0]  exp_data;
  logic        fit_clr;
  logic [3:0]  fit_count;
`endif

  int          cyc, lat, n_vec, n_err;
  logic [7:0]  res;

  always #5 clk = ~clk;

  genetico_serial_eval #(
    .N_IN  (8),
    .N_LE  (28),
`ifdef GENETICO_FITNESS_EN
    .FIT_W (4),
`endif
    .N_OUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef GENETICO_FITNESS_EN
    .exp_data  (exp_data),
    .fit_clr   (fit_clr),
    .fit_count (fit_count),
`endif
    .out_data  (out_data)
  );

  function automatic logic [14:0] gene(input logic [2:0] f, input logic [5:0] b, input logic [5:0] a);
    return {f, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input int addr, input logic [14:0] d);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start(input logic [7:0] d);
    int t = 0;
    while (!in_ready && t < 100) begin tick(); t++; end
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_valid();
    while (!out_valid && cyc < 100) tick();
    lat = cyc;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [7:0] d);
    start(d);
    wait_valid();
    res = out_data;
    release_out();
  endtask

  task automatic outs_off();
    for (int k = 0; k < 8; k++) wr(28 + k, 15'd63);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    outs_off();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef GENETICO_FITNESS_EN
    exp_data = '0; fit_clr = 1'b0;
`endif
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
`ifdef GENETICO_FITNESS_EN
    chk("rst_fit_count", fit_count, 0);
`endif
    tick();
    rst_n = 1'b1;
    #1;
    chk("in_ready_release", in_ready, 1);
    outs_off();

    // Forward XOR: LE0 = in0 ^ in1, output 0 = LE0
    wr(0, gene(3'd2, 6'd1, 6'd0)); wr(28, 15'd8);
    run(8'h03); chk("xor_03", res, 8'h00); chk("xor_lat_a", lat, 29);
    run(8'h01); chk("xor_01", res, 8'h01); chk("xor_lat_b", lat, 29);

    // Self-feedback: LE0 = in0 ^ LE0(prev)
    do_reset();
    wr(0, gene(3'd2, 6'd8, 6'd0)); wr(28, 15'd8);
    run(8'h01); chk("fb_pass1", res, 8'h01);
    run(8'h01); chk("fb_pass2", res, 8'h00);
    run(8'h01); chk("fb_pass3", res, 8'h01);

    // Forward reference: LE0 = BUF(LE1 prev), LE1 = NOT in0; out1 gene 63 -> 0, out2 = LE1
    do_reset();
    wr(0, gene(3'd7, 6'd0, 6'd9)); wr(1, gene(3'd6, 6'd0, 6'd0));
    wr(28, 15'd8); wr(29, 15'd63); wr(30, 15'd9);
    run(8'h00); chk("fwd_pass1", res, 8'h04);
    run(8'h00); chk("fwd_pass2", res, 8'h05);
    run(8'hFF); chk("fwd_range_ff", res, 8'h01);

    // Gene write during EVAL must be dropped
    start(8'h00);
    repeat (3) tick();
    chk("drop_busy_a", busy, 1);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = gene(3'd7, 6'd0, 6'd0);
    tick();
    cfg_we = 1'b0;
    chk("drop_busy_b", busy, 1);
    wait_valid(); res = out_data; release_out();
    chk("drop_lat", lat, 29);
    chk("drop_cur", res, 8'h04);
    run(8'h00); chk("drop_next_old_gene", res, 8'h05);

    // Backpressure: hold out_ready low in DONE
    start(8'h80);
    wait_valid();
    chk("bp_first", out_data, 8'h05);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_data", out_data, 8'h05);
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    release_out();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_ready_rise", in_ready, 1);

    // Reset at EVAL idx 5
    start(8'h01);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_data", out_data, 0);
`ifdef GENETICO_FITNESS_EN
    chk("mid_rst_fit", fit_count, 0);
`endif
    tick();
    rst_n = 1'b1;
    // Cleared output genes all select in0
    run(8'h01); chk("post_rst_genes", res, 8'hFF); chk("post_rst_lat", lat, 29);

`ifdef GENETICO_FITNESS_EN
    fit_clr = 1'b1; tick(); fit_clr = 1'b0;
    chk("fit_clr_idle", fit_count, 0);
    exp_data = 8'h00;
    run(8'h01); chk("fit_acc8", fit_count, 8);
    run(8'h01); chk("fit_sat", fit_count, 15);
    exp_data = 8'h1F;
    start(8'h01);
    repeat (28) tick();
    fit_clr = 1'b1;
    tick();
    fit_clr = 1'b0;
    chk("fit_clr_capt_valid", out_valid, 1);
    chk("fit_clr_capt", fit_count, 3);
    release_out();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
